// File: rtl/fifo_rd_packer_if.sv
// FIFO read port plus packed valid/ready output port of fifo_rd_packer.
// The packer connects through the master modport; the FIFO and the downstream sink use the slave side.
interface fifo_rd_packer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int PACK_RATIO = 4
);
   logic                             fifo_empty;
   logic [DATA_WIDTH-1:0]            fifo_rd_data;
   logic                             fifo_rd_en;
   logic                             out_valid;
   logic                             out_ready;
   logic [DATA_WIDTH*PACK_RATIO-1:0] out_data;
   logic [PACK_RATIO-1:0]            out_keep;

   modport master (
      input  fifo_empty, fifo_rd_data, out_ready,
      output fifo_rd_en, out_valid, out_data, out_keep
   );

   modport slave (
      output fifo_empty, fifo_rd_data, out_ready,
      input  fifo_rd_en, out_valid, out_data, out_keep
   );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops DATA_WIDTH lanes from a FIFO and packs PACK_RATIO of them (first popped in the LSBs) into one word.
// Optional partial-word flush after TIMEOUT_CYCLES idle cycles when PACKER_TIMEOUT_EN is defined.
module fifo_rd_packer #(
   parameter int DATA_WIDTH     = 8,
   parameter int PACK_RATIO     = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk_rd,
   input  logic              rst_n,
   input  logic              clear,
   fifo_rd_packer_if.master  bus,
   output logic              busy,
   output logic [15:0]       word_count
);

   localparam int CW = $clog2(PACK_RATIO + 1);
   localparam int IW = (PACK_RATIO > 1) ? $clog2(PACK_RATIO) : 1;
   localparam int WW = DATA_WIDTH * PACK_RATIO;
   localparam logic [CW-1:0] CNT_FULL = CW'(PACK_RATIO);
   localparam logic [CW-1:0] CNT_LAST = CW'(PACK_RATIO - 1);

   if (PACK_RATIO < 2) begin : g_bad_ratio
      $error("fifo_rd_packer: PACK_RATIO must be >= 2");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("fifo_rd_packer: TIMEOUT_CYCLES must be >= 1");
   end

   logic [DATA_WIDTH-1:0] lane_q [PACK_RATIO];
   logic [CW-1:0]         lane_cnt_q, lane_cnt_d;
   logic                  rd_pend_q, rd_pend_d;
   logic                  out_valid_q, out_valid_d;
   logic [WW-1:0]         out_data_q, out_data_d;
   logic [PACK_RATIO-1:0] out_keep_q, out_keep_d;
   logic [15:0]           word_count_q, word_count_d;

   logic          can_emit, handshake, last_cap, held, room, rd_en, load_full;
   logic [CW:0]   lane_sum;
   logic [WW-1:0] full_word;
   logic          load_part;
   logic [WW-1:0] part_word;
   logic [PACK_RATIO-1:0] part_keep;

   assign can_emit  = !out_valid_q || bus.out_ready;
   assign handshake = out_valid_q && bus.out_ready;
   assign last_cap  = rd_pend_q && (lane_cnt_q == CNT_LAST);
   assign held      = (lane_cnt_q == CNT_FULL);
   assign lane_sum  = {1'b0, lane_cnt_q} + {{CW{1'b0}}, rd_pend_q};
   assign room      = lane_sum < {1'b0, CNT_FULL};
   assign load_full = (last_cap || held) && can_emit;

   // Pop request is gated by rst_n so the FIFO is never popped while the packer is held in reset.
   assign rd_en = rst_n && !bus.fifo_empty && !clear &&
                  (room || (last_cap && can_emit));

   // A word completing this cycle takes its top lane straight from the FIFO read data.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      full_word = '0;
      for (int i = 0; i < PACK_RATIO; i++) begin
         full_word[i*DATA_WIDTH +: DATA_WIDTH] = lane_q[i];
      end
      if (last_cap) begin
         full_word[WW-1 -: DATA_WIDTH] = bus.fifo_rd_data;
      end
   end

`ifdef PACKER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CYCLES);

   logic [TW-1:0] idle_cnt_q, idle_cnt_d;
   logic          idle;

   assign idle      = (lane_cnt_q != '0) && (lane_cnt_q < CNT_FULL) && !rd_pend_q;
   assign load_part = idle && (idle_cnt_q == IDLE_MAX) && can_emit;

   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if (clear || rd_pend_q || !idle) begin
         idle_cnt_d = '0;
      end else if (idle_cnt_q != IDLE_MAX) begin
         idle_cnt_d = idle_cnt_q + TW'(1);
      end
   end

   always_comb begin
      part_word = '0;
      part_keep = '0;
      for (int i = 0; i < PACK_RATIO; i++) begin
         if (CW'(i) < lane_cnt_q) begin
            part_word[i*DATA_WIDTH +: DATA_WIDTH] = lane_q[i];
            part_keep[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_rd or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end
`else
   assign load_part = 1'b0;
   assign part_word = '0;
   assign part_keep = '1;
`endif

   always_comb begin
      lane_cnt_d   = lane_cnt_q;
      rd_pend_d    = rd_en;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_keep_d   = out_keep_q;
      word_count_d = word_count_q + 16'(handshake);

      if (rd_pend_q) begin
         lane_cnt_d = lane_cnt_q + CW'(1);
      end

      // Loading a new word in the handshake cycle keeps out_valid high for back-to-back words.
      if (load_full) begin
         lane_cnt_d  = '0;
         out_valid_d = 1'b1;
         out_data_d  = full_word;
         out_keep_d  = '1;
      end else if (load_part) begin
         lane_cnt_d  = '0;
         out_valid_d = 1'b1;
         out_data_d  = part_word;
         out_keep_d  = part_keep;
      end else if (handshake) begin
         out_valid_d = 1'b0;
      end

      if (clear) begin
         lane_cnt_d  = '0;
         rd_pend_d   = 1'b0;
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_rd or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         lane_cnt_q   <= '0;
         rd_pend_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_keep_q   <= '1;
         word_count_q <= '0;
      end else begin
         lane_cnt_q   <= lane_cnt_d;
         rd_pend_q    <= rd_pend_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_keep_q   <= out_keep_d;
         word_count_q <= word_count_d;
      end
   end

   // NOTE: the lane buffer has no reset; lanes are only read at or below lane_cnt, which is reset.
   always_ff @(posedge clk_rd) begin
      if (rd_pend_q && !held) begin
         lane_q[lane_cnt_q[IW-1:0]] <= bus.fifo_rd_data;
      end
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_keep   = out_keep_q;
   assign busy           = (lane_cnt_q != '0) || rd_pend_q;
   assign word_count     = word_count_q;

endmodule
